// File: rtl/framing_pkg.sv
// Shared framing-library types: arbiter FSM states and header-byte builder.
package framing_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } arb_state_t;

  // The header byte is the raw source index. Escaping is left to the framer.
  function automatic logic [7:0] header_byte(input logic [7:0] src_idx);
    return src_idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after last_grant wins.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  // Scan last_grant+1, last_grant+2, ... with wrap; stop at the first request
  always_comb begin
    int cand;
    cand         = 0;
    grant_onehot = '0;
    grant_idx    = '0;
    grant_vld    = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_grant) + off) % NUM_REQ;
      if (!grant_vld && req[IDX_W'(cand)]) begin
        grant_vld                  = 1'b1;
        grant_idx                  = IDX_W'(cand);
        grant_onehot[IDX_W'(cand)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_arbiter.sv
// Packet-granular round-robin mux of NUM_TARGETS byte streams onto one
// AXI4-Stream link, with an optional source-ID header byte per packet.
module packet_arbiter
  import framing_pkg::*;
#(
  parameter  int NUM_TARGETS = 4,
  parameter  bit INSERT_ID   = 1'b1,
  localparam int ID_WIDTH    = $clog2(NUM_TARGETS)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_TARGETS-1:0]   target_tvalid,
  output logic [NUM_TARGETS-1:0]   target_tready,
  input  logic [8*NUM_TARGETS-1:0] target_tdata,
  input  logic [NUM_TARGETS-1:0]   target_tlast,
  output logic                     initiator_tvalid,
  input  logic                     initiator_tready,
  output logic [7:0]               initiator_tdata,
  output logic                     initiator_tlast,
  output logic [ID_WIDTH-1:0]      initiator_tid
);

  arb_state_t               state;
  logic [ID_WIDTH-1:0]      grant;
  logic [NUM_TARGETS-1:0]   grant_oh;
  logic [ID_WIDTH-1:0]      last_grant;

  logic [NUM_TARGETS-1:0]   arb_oh;
  logic [ID_WIDTH-1:0]      arb_idx;
  logic                     arb_vld;

  logic                     load_en;
  logic                     vld_p0;
  logic                     last_p0;
  logic [7:0]               data_p0;

  rr_arbiter #(
    .NUM_REQ (NUM_TARGETS)
  ) u_rr_arbiter (
    .req          (target_tvalid),
    .last_grant   (last_grant),
    .grant_onehot (arb_oh),
    .grant_idx    (arb_idx),
    .grant_vld    (arb_vld)
  );

  // Output register may take a new beat when empty or being drained
  assign load_en = !initiator_tvalid || initiator_tready;

  // Only the granted source sees ready, and only while streaming its payload
  always_comb begin
    target_tready = '0;
    if (state == DATA && load_en) begin
      target_tready = grant_oh;
    end
  end

  // p0: select the granted source's beat (AND-OR mux on the one-hot grant)
  always_comb begin
    vld_p0  = |(target_tvalid & grant_oh);
    last_p0 = |(target_tlast & grant_oh);
    data_p0 = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      data_p0 = data_p0 | (target_tdata[8*i +: 8] & {8{grant_oh[i]}});
    end
  end

  // p1: arbitration FSM and the registered output stage
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state            <= IDLE;
      last_grant       <= ID_WIDTH'(NUM_TARGETS - 1);
      grant            <= '0;
      grant_oh         <= '0;
      initiator_tvalid <= 1'b0;
      initiator_tdata  <= '0;
      initiator_tlast  <= 1'b0;
      initiator_tid    <= '0;
    end else begin
      if (load_en) begin
        initiator_tvalid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (arb_vld) begin
            grant    <= arb_idx;
            grant_oh <= arb_oh;
            state    <= INSERT_ID ? HEADER : DATA;
          end
        end
        HEADER: begin
          if (load_en) begin
            initiator_tdata  <= header_byte(8'(grant));
            initiator_tlast  <= 1'b0;
            initiator_tid    <= grant;
            initiator_tvalid <= 1'b1;
            state            <= DATA;
          end
        end
        DATA: begin
          // Grant stays locked here until the granted source sends tlast
          if (vld_p0 && load_en) begin
            initiator_tdata  <= data_p0;
            initiator_tlast  <= last_p0;
            initiator_tid    <= grant;
            initiator_tvalid <= 1'b1;
            if (last_p0) begin
              last_grant <= grant;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_arbiter.sv
// Bench for packet_arbiter: packet-level round-robin reference model and
// an output scoreboard, plus directed reset and INSERT_ID=0 steps.
module tb_packet_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  // INSERT_ID=1 instance
  logic [N-1:0]   t_valid, t_ready, t_last;
  logic [8*N-1:0] t_data;
  logic           i_valid, i_ready, i_last;
  logic [7:0]     i_data;
  logic [IDW-1:0] i_tid;

  // INSERT_ID=0 instance
  logic [N-1:0]   b_t_valid, b_t_ready, b_t_last;
  logic [8*N-1:0] b_t_data;
  logic           b_i_valid, b_i_ready, b_i_last;
  logic [7:0]     b_i_data;
  logic [IDW-1:0] b_i_tid;

  packet_arbiter #(.NUM_TARGETS(N), .INSERT_ID(1'b1)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .target_tvalid    (t_valid),
    .target_tready    (t_ready),
    .target_tdata     (t_data),
    .target_tlast     (t_last),
    .initiator_tvalid (i_valid),
    .initiator_tready (i_ready),
    .initiator_tdata  (i_data),
    .initiator_tlast  (i_last),
    .initiator_tid    (i_tid)
  );

  packet_arbiter #(.NUM_TARGETS(N), .INSERT_ID(1'b0)) dut_noid (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .target_tvalid    (b_t_valid),
    .target_tready    (b_t_ready),
    .target_tdata     (b_t_data),
    .target_tlast     (b_t_last),
    .initiator_tvalid (b_i_valid),
    .initiator_tready (b_i_ready),
    .initiator_tdata  (b_i_data),
    .initiator_tlast  (b_i_last),
    .initiator_tid    (b_i_tid)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0]  src_q[N][$];   // per source: {last, data}
  logic [10:0] exp_q[$];      // {tid, last, data}
  logic [10:0] obs_q[$];
  int          m_last;        // model's last granted source

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic add_pkt(input int src, input int len, input logic [7:0] base, input bit rnd);
    for (int k = 0; k < len; k++) begin
      logic [7:0] b;
      b = rnd ? 8'($urandom) : base + 8'(k);
      src_q[src].push_back({(k == len - 1), b});
    end
  endtask

  // Whole packets leave in round-robin order among sources that still hold data
  task automatic build_expected(input bit ins_id);
    int pos[N];
    int found;
    logic [8:0] b;
    logic [IDW-1:0] fid;
    exp_q.delete();
    for (int i = 0; i < N; i++) pos[i] = 0;
    forever begin
      found = -1;
      for (int off = 1; off <= N; off++) begin
        int c;
        c = (m_last + off) % N;
        if (found < 0 && pos[c] < src_q[c].size()) found = c;
      end
      if (found < 0) break;
      fid = found[IDW-1:0];
      if (ins_id) exp_q.push_back({fid, 1'b0, 8'(found)});
      do begin
        b = src_q[found][pos[found]];
        pos[found]++;
        exp_q.push_back({fid, b});
      end while (!b[8]);
      m_last = found;
    end
  endtask

  task automatic run_traffic(input int ready_pct, input string tag);
    int cyc = 0;
    int tail = 0;
    int stall_bad = 0;
    int left = 0;
    bit stall_prev = 1'b0;
    logic [11:0] held = '0;
    build_expected(1'b1);
    obs_q.delete();
    while (cyc < 20000 && tail < 6) begin
      @(negedge aclk);
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0) begin
          t_valid[i]       = 1'b1;
          t_data[8*i +: 8] = src_q[i][0][7:0];
          t_last[i]        = src_q[i][0][8];
        end else begin
          t_valid[i]       = 1'b0;
          t_data[8*i +: 8] = 8'h00;
          t_last[i]        = 1'b0;
        end
      end
      i_ready = (obs_q.size() >= exp_q.size()) ? 1'b1 : ($urandom_range(99) < ready_pct);
      #1;
      if (stall_prev && {i_valid, i_tid, i_last, i_data} !== held) stall_bad++;
      stall_prev = i_valid && !i_ready;
      held       = {i_valid, i_tid, i_last, i_data};
      for (int i = 0; i < N; i++) begin
        if (t_valid[i] && t_ready[i]) void'(src_q[i].pop_front());
      end
      if (i_valid && i_ready) obs_q.push_back({i_tid, i_last, i_data});
      if (obs_q.size() >= exp_q.size()) tail++;
      cyc++;
    end
    @(negedge aclk);
    t_valid = '0;
    t_last  = '0;
    t_data  = '0;
    i_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      left += src_q[i].size();
      src_q[i].delete();
    end
    check({tag, " beat_count"}, obs_q.size(), exp_q.size());
    check({tag, " sources_drained"}, left, 0);
    check({tag, " stall_stable"}, stall_bad, 0);
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      check($sformatf("%s beat%0d", tag, k), obs_q[k], exp_q[k]);
    end
  endtask

  initial begin
    int hit;
    aresetn   = 1'b0;
    t_valid   = '0;  t_last = '0;  t_data = '0;  i_ready = 1'b1;
    b_t_valid = '0;  b_t_last = '0; b_t_data = '0; b_i_ready = 1'b1;
    m_last    = N - 1;

    // Reset state
    repeat (3) @(negedge aclk);
    #1;
    check("rst tvalid", i_valid, 0);
    check("rst tdata",  i_data, 0);
    check("rst tlast",  i_last, 0);
    check("rst tid",    i_tid, 0);
    check("rst tready", t_ready, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Single source 0: A1 A2 A3
    add_pkt(0, 3, 8'hA1, 1'b0);
    run_traffic(100, "src0");
    check("src0 hdr", obs_q.size() > 0 ? obs_q[0] : 11'h7ff, {2'd0, 1'b0, 8'h00});
    check("src0 end", obs_q.size() > 3 ? obs_q[3] : 11'h7ff, {2'd0, 1'b1, 8'hA3});

    // Sources 1 and 3 together, 2-byte packets
    add_pkt(1, 2, 8'h10, 1'b0);
    add_pkt(3, 2, 8'h30, 1'b0);
    run_traffic(100, "src13");

    // All four sources, three packets each
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < N; s++) add_pkt(s, 1 + ((s + p) % 3), 8'(16 * s + 4 * p), 1'b0);
    run_traffic(100, "all4");

    // 100 random packets under 50% output ready
    for (int p = 0; p < 100; p++) add_pkt($urandom_range(N - 1), $urandom_range(1, 4), 8'h00, 1'b1);
    run_traffic(50, "rand");

    // Reset in the middle of a packet
    @(negedge aclk);
    t_valid[0]  = 1'b1;
    t_data[7:0] = 8'hC0;
    t_last[0]   = 1'b0;
    i_ready     = 1'b1;
    hit = 0;
    for (int c = 0; c < 20 && hit == 0; c++) begin
      @(negedge aclk);
      #1;
      if (i_valid && i_tid == 2'd0 && i_data == 8'hC0) hit = 1;
    end
    check("midrst reached_data", hit, 1);
    aresetn = 1'b0;
    #1;
    check("midrst tvalid", i_valid, 0);
    check("midrst tready", t_ready, 0);
    t_valid = '0;
    t_data  = '0;
    @(negedge aclk);
    aresetn = 1'b1;
    m_last  = N - 1;
    add_pkt(2, 2, 8'h20, 1'b0);
    add_pkt(1, 1, 8'h11, 1'b0);
    run_traffic(100, "postrst");

    // INSERT_ID=0: single-beat packet 5A from source 2
    @(negedge aclk);
    b_t_valid[2]      = 1'b1;
    b_t_data[23:16]   = 8'h5A;
    b_t_last[2]       = 1'b1;
    hit = 0;
    for (int c = 0; c < 10 && hit == 0; c++) begin
      @(negedge aclk);
      #1;
      check("noid early_valid", b_i_valid, 0);
      if (b_t_ready[2]) hit = 1;
    end
    check("noid tready", hit, 1);
    @(negedge aclk);
    b_t_valid = '0;
    b_t_last  = '0;
    b_t_data  = '0;
    #1;
    check("noid tvalid", b_i_valid, 1);
    check("noid tdata",  b_i_data, 8'h5A);
    check("noid tlast",  b_i_last, 1);
    check("noid tid",    b_i_tid, 2);
    @(negedge aclk);
    #1;
    check("noid no_dup", b_i_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_arbiter.md
Name: packet_arbiter

Overview:
Shares one byte-wide AXI4-Stream link between NUM_TARGETS packet sources, e.g. several command producers feeding a single framer/UART path. Round-robin arbitration at packet granularity: a grant is held until the granted source completes its packet with tlast.
Optionally prepends one source-ID byte to each packet so the receive side, after deframing, can demultiplex.
Output is a single registered stage with the same ready/valid rule as the rest of the framing library.

Parameters:
NUM_TARGETS, 4, number of requester streams; legal range 2..256.
INSERT_ID, 1'b1, 1 = emit a header byte (source index) before each packet; 0 = pass packets unchanged.
ID_WIDTH (localparam), $clog2(NUM_TARGETS), width of initiator_tid.

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
target_tvalid  in  NUM_TARGETS  per-source valid
target_tready  out  NUM_TARGETS  per-source ready
target_tdata  in  8*NUM_TARGETS  per-source byte; source i occupies bits [8*i+7:8*i]
target_tlast  in  NUM_TARGETS  per-source end of packet
initiator_tvalid  out  1  output valid
initiator_tready  in  1  output ready
initiator_tdata  out  8  output byte
initiator_tlast  out  1  output end of packet
initiator_tid  out  ID_WIDTH  index of the source that owns the current output beat

Behaviour:
- Reset (async assert, sync release):
  - initiator_tvalid=0, initiator_tdata=0, initiator_tlast=0, initiator_tid=0.
  - state=IDLE, last_grant=NUM_TARGETS-1, so source 0 has first priority.
- load_en = !initiator_tvalid || initiator_tready.
- initiator_tvalid clears on load_en unless a new beat is loaded in the same cycle.
- target_tready is combinational:
  - target_tready[grant] = load_en only in state DATA.
  - All other bits are 0; all bits are 0 in IDLE and HEADER.
- State IDLE:
  - If no target_tvalid bit is set, stay in IDLE.
  - Otherwise grant <= first index with valid set, searching last_grant+1, last_grant+2, ... with wrap modulo NUM_TARGETS.
  - Next state is HEADER if INSERT_ID, else DATA.
  - Arbitration costs exactly one cycle; no data moves in IDLE.
- State HEADER, on load_en:
  - initiator_tdata <= grant zero-extended to 8 bits; tlast <= 0; tid <= grant; tvalid <= 1.
  - Next state DATA. The header is never escaped here; escaping is the framer's job.
- State DATA, on target_tvalid[grant] && target_tready[grant]:
  - Register the byte, tlast and tid=grant; tvalid <= 1.
  - If target_tlast[grant]: last_grant <= grant, state <= IDLE.
- Grant lock: the grant is held for the whole packet regardless of other requests. It is also held if the granted source deasserts tvalid mid-packet (an AXI violation, but no hang: the block waits).
- Throughput:
  - Full rate within a packet under continuous ready.
  - Per-packet overhead is 1 cycle (IDLE) plus 1 beat (HEADER) when INSERT_ID=1.
- Single-beat packet (tlast on first data beat) is legal.
  - INSERT_ID=1: output is two beats, header then data with tlast=1.
- Backpressure:
  - Output register holds stable while initiator_tvalid && !initiator_tready.
  - No beat is dropped or duplicated.
- Simultaneous requests: strictly round-robin. With all sources always valid, grants run 0,1,2,...,N-1,0,...
- Reset mid-packet:
  - Packet is truncated; initiator_tvalid drops immediately.
  - After release, arbitration restarts from source 0 priority.
  - The partially consumed source must be reset too; that is the system's responsibility.

Decomposition:
- Shared package framing_pkg holds the state enum typedef (IDLE, HEADER, DATA) and the header-byte construction function.
- One natural sub-module: rr_arbiter. It takes the request vector and last_grant, and returns a one-hot grant plus index (combinational). It is reusable by future multi-channel blocks.

Test Plan:
- Single source 0 sends A1 A2 A3 (tlast on A3), INSERT_ID=1, ready=1 -> output 00 A1 A2 A3, tlast only on A3, tid=0 on all 4 beats.
- Sources 1 and 3 both valid at reset release, 2-byte packets -> source 1 packet (header 01) fully precedes source 3 packet (header 03); no interleaving.
- All 4 sources continuously valid, 3 packets each -> grant order 0,1,2,3 repeated 3 times; each packet contiguous.
- initiator_tready toggles randomly at 50% over 100 packets -> scoreboard matches every byte per source; output stable while stalled.
- INSERT_ID=0, single-beat packet 5A from source 2 -> output one beat 5A, tlast=1, tid=2.
- aresetn asserted mid-packet in DATA -> initiator_tvalid=0 that cycle. After release, a new packet from source 2 is arbitrated normally with header 02.
